// File: rtl/viterbi_pkg.sv
`default_nettype none
// ============================================================================
// viterbi_pkg : shared types and helpers for the survivor-memory scheduler
// Rev 1.0
// ============================================================================
package viterbi_pkg;

    localparam int NBANK = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } sched_state_e;

    // Bank role offset relative to the current write bank, modulo 4
    function automatic logic [1:0] bank_off(input logic [1:0] wr_bank, input logic [1:0] k);
        return wr_bank + k;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tb_sched_if.sv
`default_nettype none
// ============================================================================
// tb_sched_if : control/bank bus between the ACS stage, scheduler and memories
// Rev 1.0
// ============================================================================
interface tb_sched_if #(
    parameter int ADDR_W = 10
);
    import viterbi_pkg::*;

    logic                   enable;
    logic                   start;
    logic                   flush;
    logic                   sel_valid;
    logic                   sel_ready;
    logic [3:0]             mem_wr;
    logic [4*ADDR_W-1:0]    mem_addr;
    logic [1:0]             tbu_en;
    logic [1:0]             tbu_sel;
    logic [1:0]             rd_bank_new;
    logic [1:0]             rd_bank_old;
    logic                   disp_bank;
    logic                   busy;
    logic                   done;

    modport master (
        output enable, start, flush, sel_valid,
        input  sel_ready, mem_wr, mem_addr, tbu_en, tbu_sel,
               rd_bank_new, rd_bank_old, disp_bank, busy, done
    );

    modport slave (
        input  enable, start, flush, sel_valid,
        output sel_ready, mem_wr, mem_addr, tbu_en, tbu_sel,
               rd_bank_new, rd_bank_old, disp_bank, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/tb_sched_bank_ptr.sv
`default_nettype none
// ============================================================================
// tb_bank_ptr : write/read pointers and write-bank rotation for the scheduler
// Rev 1.0
// ============================================================================
module tb_bank_ptr #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              accept_i,
    input  logic              drain_i,
    output logic [ADDR_W-1:0] wr_ptr_o,
    output logic [ADDR_W-1:0] rd_ptr_o,
    output logic [1:0]        wr_bank_o,
    output logic              wrap_o
);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PTR_MAX = '1;

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [1:0]        wr_bank_q, wr_bank_d;
    logic              wrap;

    // During drain the read pointer alone paces the bank rotation
    assign wrap = (accept_i && (wr_ptr_q == PTR_MAX)) || (drain_i && (rd_ptr_q == '0));

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        wr_bank_d = wr_bank_q;
        if (clr_i) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = PTR_MAX;
            wr_bank_d = '0;
        end else begin
            if (accept_i) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                rd_ptr_d = rd_ptr_q - PTR_ONE;
            end else if (drain_i) begin
                rd_ptr_d = rd_ptr_q - PTR_ONE;
            end
            if (wrap) begin
                wr_bank_d = wr_bank_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= PTR_MAX;
            wr_bank_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_bank_q <= wr_bank_d;
        end
    end

    assign wr_ptr_o  = wr_ptr_q;
    assign rd_ptr_o  = rd_ptr_q;
    assign wr_bank_o = wr_bank_q;
    assign wrap_o    = wrap && !clr_i;

endmodule
`default_nettype wire

// File: rtl/tb_sched.sv
`default_nettype none
// ============================================================================
// tb_sched : survivor-bank / traceback-unit sequencer for the K=4 Viterbi core
// Rev 1.0
// ============================================================================
module tb_sched #(
    parameter int ADDR_W = 10,
    parameter int NBANK  = 4
) (
    input  logic      clk,
    input  logic      rst,
    tb_sched_if.slave bus
);
    import viterbi_pkg::*;

    if (NBANK != 4) begin : g_nbank_check
        $error("tb_sched: NBANK must be 4");
    end

    localparam logic [ADDR_W:0] DRAIN_LAST = '1;
    localparam logic [ADDR_W:0] DCNT_ONE   = (ADDR_W+1)'(1);

    sched_state_e            state_q, state_d;
    logic [1:0]              cnt_q, cnt_d;
    logic [ADDR_W:0]         dcnt_q, dcnt_d;
    logic                    sel_ready_q, sel_ready_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [3:0]              mem_wr_q, mem_wr_d;
    logic [NBANK*ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [1:0]              tbu_en_q, tbu_en_d;
    logic [1:0]              tbu_sel_q, tbu_sel_d;
    logic [1:0]              rd_new_q, rd_new_d;
    logic [1:0]              rd_old_q, rd_old_d;
    logic [2:0]              disp_q, disp_d;

    logic                    accept;
    logic                    ptr_clr;
    logic                    drain_step;
    logic                    wrap;
    logic [ADDR_W-1:0]       wr_ptr;
    logic [ADDR_W-1:0]       rd_ptr;
    logic [1:0]              wr_bank;
    logic                    roles_on;
    logic                    addr_on;

    assign accept     = bus.sel_valid && sel_ready_q;
    assign ptr_clr    = !bus.enable || ((state_q == IDLE) && bus.start);
    assign drain_step = bus.enable && (state_q == DRAIN);

    tb_bank_ptr #(.ADDR_W(ADDR_W)) u_bank_ptr (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (ptr_clr),
        .accept_i  (accept),
        .drain_i   (drain_step),
        .wr_ptr_o  (wr_ptr),
        .rd_ptr_o  (rd_ptr),
        .wr_bank_o (wr_bank),
        .wrap_o    (wrap)
    );

    always_comb begin
        state_d = state_q;
        dcnt_d  = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                // A wrap completing the second bank in the flush cycle still yields a traceable pair
                if (bus.flush) begin
                    state_d = (wrap && (cnt_q == 2'd1)) ? DRAIN : IDLE;
                end else if (wrap && (cnt_q == 2'd1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                dcnt_d = dcnt_q + DCNT_ONE;
                if (dcnt_q == DRAIN_LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!bus.enable) begin
            state_d = IDLE;
        end

        cnt_d = cnt_q;
        if ((state_q == IDLE) || !bus.enable) begin
            cnt_d = '0;
        end else if (accept && wrap && (cnt_q != 2'd2)) begin
            cnt_d = cnt_q + 2'd1;
        end

        roles_on    = (state_q != IDLE) && (state_d != IDLE);
        addr_on     = bus.enable && (state_q != IDLE) && ((state_d != IDLE) || accept);
        sel_ready_d = (state_d == FILL) || (state_d == RUN);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DRAIN) && (dcnt_d == DRAIN_LAST);
        mem_wr_d    = (accept && bus.enable) ? (4'b0001 << wr_bank) : 4'b0000;

        mem_addr_d = '0;
        if (addr_on) begin
            for (int b = 0; b < NBANK; b++) begin
                if (2'(b) == wr_bank) begin
                    mem_addr_d[b*ADDR_W +: ADDR_W] = wr_ptr;
                end else if (2'(b) == bank_off(wr_bank, 2'd2)) begin
                    mem_addr_d[b*ADDR_W +: ADDR_W] = '0;
                end else begin
                    mem_addr_d[b*ADDR_W +: ADDR_W] = rd_ptr;
                end
            end
        end

        tbu_en_d = '0;
        if (state_d != IDLE) begin
            tbu_en_d = tbu_en_q | {wrap && (wr_bank == 2'd2), wrap && (wr_bank == 2'd1)};
        end

        tbu_sel_d = roles_on ? {~wr_bank[0], wr_bank[0]} : 2'b00;
        rd_new_d  = roles_on ? bank_off(wr_bank, 2'd3) : 2'b00;
        rd_old_d  = roles_on ? bank_off(wr_bank, 2'd1) : 2'b00;
        disp_d    = bus.enable ? {disp_q[1:0], roles_on && wr_bank[0]} : 3'b000;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dcnt_q      <= '0;
            sel_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_wr_q    <= '0;
            mem_addr_q  <= '0;
            tbu_en_q    <= '0;
            tbu_sel_q   <= '0;
            rd_new_q    <= '0;
            rd_old_q    <= '0;
            disp_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dcnt_q      <= dcnt_d;
            sel_ready_q <= sel_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            tbu_en_q    <= tbu_en_d;
            tbu_sel_q   <= tbu_sel_d;
            rd_new_q    <= rd_new_d;
            rd_old_q    <= rd_old_d;
            disp_q      <= disp_d;
        end
    end

    assign bus.sel_ready   = sel_ready_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.mem_wr      = mem_wr_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.tbu_en      = tbu_en_q;
    assign bus.tbu_sel     = tbu_sel_q;
    assign bus.rd_bank_new = rd_new_q;
    assign bus.rd_bank_old = rd_old_q;
    assign bus.disp_bank   = disp_q[2];

endmodule
`default_nettype wire

// File: tb/tb_tb_sched.sv
`default_nettype none
// ============================================================================
// tb_tb_sched : directed self-checking bench for tb_sched (ADDR_W=3, DEPTH=8)
// Rev 1.0
// ============================================================================
module tb_tb_sched;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    tb_sched_if #(.ADDR_W(AW)) bus ();

    tb_sched #(.ADDR_W(AW), .NBANK(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one accepted word number w (counted from the last start) and checks the bank roles
    task automatic accept_word(input int w);
        int b;
        int a;
        b = (w / DEPTH) % 4;
        a = w % DEPTH;
        bus.sel_valid = 1'b1;
        step();
        check_eq("wr_onehot",  32'(bus.mem_wr), 32'(1 << b));
        check_eq("wr_addr",    32'(bus.mem_addr[b*AW +: AW]), 32'(a));
        check_eq("idle_addr",  32'(bus.mem_addr[((b+2)%4)*AW +: AW]), 32'd0);
        check_eq("rd_old_addr", 32'(bus.mem_addr[((b+1)%4)*AW +: AW]), 32'(DEPTH-1-a));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        int done_seen;

        bus.enable    = 1'b1;
        bus.start     = 1'b0;
        bus.flush     = 1'b0;
        bus.sel_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        step();
        check_eq("rst_busy",      32'(bus.busy), 32'd0);
        check_eq("rst_ready",     32'(bus.sel_ready), 32'd0);
        check_eq("rst_mem_wr",    32'(bus.mem_wr), 32'd0);
        check_eq("rst_mem_addr",  32'(bus.mem_addr), 32'd0);
        check_eq("rst_tbu_en",    32'(bus.tbu_en), 32'd0);
        check_eq("rst_done",      32'(bus.done), 32'd0);

        // Fill: two banks
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check_eq("fill_busy",  32'(bus.busy), 32'd1);
        check_eq("fill_ready", 32'(bus.sel_ready), 32'd1);
        for (int w = 0; w < 16; w++) accept_word(w);
        check_eq("fill_tbu_en", 32'(bus.tbu_en), 32'h1);
        bus.sel_valid = 1'b0;
        step();
        check_eq("fill_rd_new",  32'(bus.rd_bank_new), 32'd1);
        check_eq("fill_rd_old",  32'(bus.rd_bank_old), 32'd3);
        check_eq("fill_tbu_sel", 32'(bus.tbu_sel), 32'h2);

        // Steady rotation: 40 more words through banks 2,3,0,1,2
        for (int w = 16; w < 56; w++) accept_word(w);
        check_eq("run_tbu_en", 32'(bus.tbu_en), 32'h3);
        bus.sel_valid = 1'b0;
        step();
        step();
        check_eq("disp_before", 32'(bus.disp_bank), 32'd0);
        step();
        check_eq("disp_after",  32'(bus.disp_bank), 32'd1);

        // Stall: accepts only on alternate cycles, bank 3 then wrap to 0
        n = 56;
        for (int c = 0; c < 16; c++) begin
            if (c % 2 == 0) begin
                accept_word(n);
                n++;
            end else begin
                bus.sel_valid = 1'b0;
                step();
                check_eq("gap_mem_wr", 32'(bus.mem_wr), 32'd0);
                check_eq("gap_rd_new", 32'(bus.rd_bank_new), 32'(((n / DEPTH) + 3) % 4));
                check_eq("gap_rd_addr", 32'(bus.mem_addr[(((n / DEPTH) + 1) % 4)*AW +: AW]),
                         32'(DEPTH-1-(n % DEPTH)));
            end
        end

        // Flush from RUN: 16 drain cycles, one done pulse
        bus.sel_valid = 1'b0;
        bus.flush     = 1'b1;
        step();
        bus.flush = 1'b0;
        check_eq("drain_ready", 32'(bus.sel_ready), 32'd0);
        check_eq("drain_busy",  32'(bus.busy), 32'd1);
        done_seen = 0;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (bus.done) done_seen++;
            check_eq("drain_mem_wr", 32'(bus.mem_wr), 32'd0);
            check_eq("drain_done",   32'(bus.done), 32'(k == 15));
            if (k <= 15) begin
                check_eq("drain_rd_new", 32'(bus.rd_bank_new), 32'((((k-1) / DEPTH) + 3) % 4));
                check_eq("drain_rd_addr", 32'(bus.mem_addr[((((k-1) / DEPTH) + 1) % 4)*AW +: AW]),
                         32'(DEPTH-1-((k-1) % DEPTH)));
            end
            if (k == 15) check_eq("drain_busy_last", 32'(bus.busy), 32'd1);
        end
        check_eq("drain_idle",      32'(bus.busy), 32'd0);
        check_eq("drain_done_cnt",  32'(done_seen), 32'd1);

        // Flush from FILL: back to IDLE, no done
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int w = 0; w < 5; w++) accept_word(w);
        bus.sel_valid = 1'b0;
        bus.flush     = 1'b1;
        step();
        bus.flush = 1'b0;
        check_eq("fflush_busy",  32'(bus.busy), 32'd0);
        check_eq("fflush_ready", 32'(bus.sel_ready), 32'd0);
        done_seen = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (bus.done) done_seen++;
        end
        check_eq("fflush_done_cnt", 32'(done_seen), 32'd0);
        check_eq("fflush_tbu_en",   32'(bus.tbu_en), 32'd0);

        // enable low mid-RUN
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int w = 0; w < 20; w++) accept_word(w);
        bus.sel_valid = 1'b0;
        bus.enable    = 1'b0;
        step();
        check_eq("en_busy",     32'(bus.busy), 32'd0);
        check_eq("en_ready",    32'(bus.sel_ready), 32'd0);
        check_eq("en_mem_wr",   32'(bus.mem_wr), 32'd0);
        check_eq("en_mem_addr", 32'(bus.mem_addr), 32'd0);
        check_eq("en_tbu_en",   32'(bus.tbu_en), 32'd0);
        check_eq("en_rd_old",   32'(bus.rd_bank_old), 32'd0);
        bus.enable = 1'b1;
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        accept_word(0);

        // Asynchronous reset mid-RUN
        for (int w = 1; w < 20; w++) accept_word(w);
        #2 rst = 1'b0;
        #1;
        check_eq("arst_busy",   32'(bus.busy), 32'd0);
        check_eq("arst_mem_wr", 32'(bus.mem_wr), 32'd0);
        check_eq("arst_ready",  32'(bus.sel_ready), 32'd0);
        step();
        check_eq("arst_tbu_en", 32'(bus.tbu_en), 32'd0);
        check_eq("arst_busy2",  32'(bus.busy), 32'd0);
        rst = 1'b1;
        bus.sel_valid = 1'b0;
        step();
        check_eq("arst_stay_idle", 32'(bus.busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
